ex_muldiv: RTL

Multi-cycle RV32M multiply/divide unit inside the execute stage. It consumes the operation, operands and destination produced by the ID/EX pipeline register. It holds the front of the pipeline through the stall controller while it works, then returns one result with its write-back tag. Plain ALU operations bypass it.

---
 rtl/ex_muldiv_pkg.sv | 46 ++++
 rtl/ex_muldiv_div_core.sv | 67 ++++++
 rtl/ex_muldiv.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared op codes, constants and op-class helpers for ex_muldiv
package ex_muldiv_pkg;

    localparam int ALU_OP_W = 8;
    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t EXE_NOP    = 8'h00;
    localparam alu_op_t EXE_MUL    = 8'h40;
    localparam alu_op_t EXE_MULH   = 8'h41;
    localparam alu_op_t EXE_MULHSU = 8'h42;
    localparam alu_op_t EXE_MULHU  = 8'h43;
    localparam alu_op_t EXE_DIV    = 8'h44;
    localparam alu_op_t EXE_DIVU   = 8'h45;
    localparam alu_op_t EXE_REM    = 8'h46;
    localparam alu_op_t EXE_REMU   = 8'h47;

    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
    localparam logic        WRITE_DISABLE = 1'b0;

    function automatic logic is_mop(input alu_op_t op);
        return op inside {EXE_MUL, EXE_MULH, EXE_MULHSU, EXE_MULHU,
                          EXE_DIV, EXE_DIVU, EXE_REM, EXE_REMU};
    endfunction

    function automatic logic is_mul_op(input alu_op_t op);
        return op inside {EXE_MUL, EXE_MULH, EXE_MULHSU, EXE_MULHU};
    endfunction

    function automatic logic mul_a_signed(input alu_op_t op);
        return op inside {EXE_MUL, EXE_MULH, EXE_MULHSU};
    endfunction

    function automatic logic mul_b_signed(input alu_op_t op);
        return op inside {EXE_MUL, EXE_MULH};
    endfunction

    function automatic logic is_div_signed(input alu_op_t op);
        return op inside {EXE_DIV, EXE_REM};
    endfunction

    function automatic logic is_rem(input alu_op_t op);
        return op inside {EXE_REM, EXE_REMU};
    endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// rtl/ex_muldiv_div_core.sv - iterative restoring divider on unsigned magnitudes, one bit per cycle
module ex_muldiv_div_core
    import ex_muldiv_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        last_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    localparam int CNT_W = $clog2(DIV_ITER + 1);

    logic [31:0]      quo_q;
    logic [31:0]      rem_q;
    logic [31:0]      dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] quo_nx;
    logic [31:0] rem_nx;

    // Borrow out of the 33-bit trial subtraction means the divisor did not fit.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fits    = ~diff[32];
    assign quo_nx  = {quo_q[30:0], fits};
    assign rem_nx  = fits ? diff[31:0] : shifted[31:0];

    // Results are offered one step early so the owner can register them on the final edge.
    assign last_o      = busy_q && (cnt_q == CNT_W'(DIV_ITER - 1));
    assign quotient_o  = quo_nx;
    assign remainder_o = rem_nx;

    always_ff @(posedge clk) begin
        if (!rst || abort_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q + 1'b1;
            if (last_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - multi-cycle RV32M multiply/divide unit for the execute stage
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    aluop_i,
    input  logic [31:0]   reg1_i,
    input  logic [31:0]   reg2_i,
    input  logic [4:0]    wd_i,
    input  logic          wreg_i,
    input  logic          flush_i,
    output logic          stall_req_o,
    output logic [31:0]   result_o,
    output logic          valid_o,
    output logic [4:0]    wd_o,
    output logic          wreg_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    alu_op_t     op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  wd_q, wd_d;
    logic        wreg_q, wreg_d;
    logic [31:0] result_q, result_d;
    logic        valid_q, valid_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;

    logic        div_start;
    logic        core_last;
    logic [31:0] core_quo;
    logic [31:0] core_rem;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf;
    logic [31:0] special_res;

    logic [32:0]        a_ext, b_ext;
    logic signed [63:0] prod;
    logic [31:0]        mul_res;
    logic [31:0]        q_fix, r_fix, div_res;

    assign a_neg = is_div_signed(aluop_i) & reg1_i[31];
    assign b_neg = is_div_signed(aluop_i) & reg2_i[31];
    assign a_mag = a_neg ? (~reg1_i + 32'd1) : reg1_i;
    assign b_mag = b_neg ? (~reg2_i + 32'd1) : reg2_i;

    assign div_zero = (reg2_i == 32'h0000_0000);
    assign div_ovf  = is_div_signed(aluop_i) && (reg1_i == 32'h8000_0000)
                      && (reg2_i == 32'hFFFF_FFFF);
    assign special_res = div_zero ? (is_rem(aluop_i) ? reg1_i : 32'hFFFF_FFFF)
                                  : (is_rem(aluop_i) ? 32'h0000_0000 : 32'h8000_0000);

    // Low 64 bits of the 33x33 signed product; the top two bits are never selected.
    assign a_ext   = {mul_a_signed(op_q) & a_q[31], a_q};
    assign b_ext   = {mul_b_signed(op_q) & b_q[31], b_q};
    assign prod    = $signed(a_ext) * $signed(b_ext);
    assign mul_res = (op_q == EXE_MUL) ? prod[31:0] : prod[63:32];

    assign q_fix   = q_neg_q ? (~core_quo + 32'd1) : core_quo;
    assign r_fix   = r_neg_q ? (~core_rem + 32'd1) : core_rem;
    assign div_res = is_rem(op_q) ? r_fix : q_fix;

    ex_muldiv_div_core #(
        .DIV_ITER (DIV_ITER)
    ) u_div_core (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .abort_i     (flush_i),
        .dividend_i  (a_mag),
        .divisor_i   (b_mag),
        .last_o      (core_last),
        .quotient_o  (core_quo),
        .remainder_o (core_rem)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        result_d    = result_q;
        valid_d     = 1'b0;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        div_start   = 1'b0;
        stall_req_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_mop(aluop_i) && !flush_i) begin
                    stall_req_o = 1'b1;
                    op_d        = aluop_i;
                    a_d         = reg1_i;
                    b_d         = reg2_i;
                    wd_d        = wd_i;
                    wreg_d      = wreg_i;
                    if (is_mul_op(aluop_i)) begin
                        state_d = S_MUL;
                    end else if (div_zero || div_ovf) begin
                        result_d = special_res;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        div_start = 1'b1;
                        q_neg_d   = a_neg ^ b_neg;
                        r_neg_d   = a_neg;
                        state_d   = S_DIV;
                    end
                end
            end
            S_MUL: begin
                stall_req_o = 1'b1;
                result_d    = mul_res;
                valid_d     = 1'b1;
                state_d     = S_DONE;
            end
            S_DIV: begin
                stall_req_o = 1'b1;
                if (core_last) begin
                    result_d = div_res;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d     = S_IDLE;
            valid_d     = 1'b0;
            div_start   = 1'b0;
            stall_req_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= EXE_NOP;
            a_q      <= ZERO_WORD;
            b_q      <= ZERO_WORD;
            wd_q     <= NOP_REG_ADDR;
            wreg_q   <= WRITE_DISABLE;
            result_q <= ZERO_WORD;
            valid_q  <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
        end
    end

    // A flush landing on the DONE cycle must still swallow the strobe.
    assign valid_o  = valid_q & ~flush_i;
    assign result_o = result_q;
    assign wd_o     = wd_q;
    assign wreg_o   = valid_o & wreg_q;

endmodule
